// File: rtl/fft_ram_pkg.sv
// Shared types and helpers for the two-bank FFT sample memory.
package fft_ram_pkg;

    typedef enum logic [2:0] {
        BANK_FREE,
        BANK_FILL,
        BANK_READY,
        BANK_COMPUTE,
        BANK_DRAIN
    } bank_state_e;

    typedef logic role_sel_t;

    // Reverse the low 'size' bits of k; higher bits of the result are zero.
    function automatic int unsigned bitrev(input int unsigned k, input int unsigned size);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < size; i++) begin
            r[i] = k[size - 1 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_ram_bank.sv
// One N-deep complex bank: two write ports (b has priority) and two
// enable-gated registered read ports.
module fft_ram_bank
    import fft_ram_pkg::*;
#(
    parameter int bit_width = 29,
    parameter int SIZE      = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        we_a,
    input  logic [SIZE-1:0]             waddr_a,
    input  logic signed [bit_width-1:0] wre_a,
    input  logic signed [bit_width-1:0] wim_a,
    input  logic                        we_b,
    input  logic [SIZE-1:0]             waddr_b,
    input  logic signed [bit_width-1:0] wre_b,
    input  logic signed [bit_width-1:0] wim_b,
    input  logic                        re_a,
    input  logic [SIZE-1:0]             raddr_a,
    input  logic                        re_b,
    input  logic [SIZE-1:0]             raddr_b,
    output logic signed [bit_width-1:0] rre_a,
    output logic signed [bit_width-1:0] rim_a,
    output logic signed [bit_width-1:0] rre_b,
    output logic signed [bit_width-1:0] rim_b
);

    localparam int N = 1 << SIZE;

    logic signed [bit_width-1:0] mem_re [N];
    logic signed [bit_width-1:0] mem_im [N];

    logic signed [bit_width-1:0] rre_a_d, rim_a_d, rre_b_d, rim_b_d;
    logic signed [bit_width-1:0] rre_a_q, rim_a_q, rre_b_q, rim_b_q;

    // NOTE: storage has no reset so it maps onto plain RAM; the second
    // non-blocking write to one address lands last, giving port b priority.
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem_re[waddr_a] <= wre_a;
            mem_im[waddr_a] <= wim_a;
        end
        if (we_b) begin
            mem_re[waddr_b] <= wre_b;
            mem_im[waddr_b] <= wim_b;
        end
    end

    // Read registers hold while disabled, keeping stalled output data stable.
    always_comb begin
        rre_a_d = re_a ? mem_re[raddr_a] : rre_a_q;
        rim_a_d = re_a ? mem_im[raddr_a] : rim_a_q;
        rre_b_d = re_b ? mem_re[raddr_b] : rre_b_q;
        rim_b_d = re_b ? mem_im[raddr_b] : rim_b_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rre_a_q <= '0;
            rim_a_q <= '0;
            rre_b_q <= '0;
            rim_b_q <= '0;
        end else begin
            rre_a_q <= rre_a_d;
            rim_a_q <= rim_a_d;
            rre_b_q <= rre_b_d;
            rim_b_q <= rim_b_d;
        end
    end

    assign rre_a = rre_a_q;
    assign rim_a = rim_a_q;
    assign rre_b = rre_b_q;
    assign rim_b = rim_b_q;

endmodule

// File: rtl/fft_pingpong_ram.sv
// Ping-pong complex sample memory: one bank fills while the other computes
// or drains; frames advance strictly FIFO through three role pointers.
module fft_pingpong_ram
    import fft_ram_pkg::*;
#(
    parameter int bit_width   = 29,
    parameter int N           = 16,
    parameter int SIZE        = 4,
    parameter int BITREV_LOAD = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic signed [bit_width-1:0] load_re,
    input  logic signed [bit_width-1:0] load_im,
    output logic                        compute_start,
    output logic                        compute_bank,
    input  logic                        compute_done,
    input  logic                        rd_en,
    input  logic [SIZE-1:0]             rd_ptr_a,
    input  logic [SIZE-1:0]             rd_ptr_b,
    output logic signed [bit_width-1:0] rd_re_a,
    output logic signed [bit_width-1:0] rd_im_a,
    output logic signed [bit_width-1:0] rd_re_b,
    output logic signed [bit_width-1:0] rd_im_b,
    output logic                        rd_valid,
    input  logic                        wr_en,
    input  logic [SIZE-1:0]             wr_ptr_a,
    input  logic [SIZE-1:0]             wr_ptr_b,
    input  logic signed [bit_width-1:0] wr_re_a,
    input  logic signed [bit_width-1:0] wr_im_a,
    input  logic signed [bit_width-1:0] wr_re_b,
    input  logic signed [bit_width-1:0] wr_im_b,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [bit_width-1:0] out_re,
    output logic signed [bit_width-1:0] out_im,
    output logic                        out_last
);

    localparam logic [SIZE-1:0] LOAD_LAST = SIZE'(N - 1);
    localparam logic [SIZE:0]   DRAIN_END = (SIZE + 1)'(N);
    localparam logic [SIZE:0]   DRAIN_LAST = (SIZE + 1)'(N - 1);

    bank_state_e     state_d [2];
    bank_state_e     state_q [2];
    role_sel_t       fill_sel_d, fill_sel_q, comp_sel_d, comp_sel_q, drain_sel_d, drain_sel_q;
    logic [SIZE-1:0] load_cnt_d, load_cnt_q;
    logic [SIZE:0]   drain_cnt_d, drain_cnt_q;
    logic            compute_start_d, compute_start_q, compute_bank_d, compute_bank_q;
    logic            rd_valid_d, rd_valid_q;
    logic            out_valid_d, out_valid_q, out_last_d, out_last_q, out_bank_d, out_bank_q;

    logic            fill_ok, comp_active, rd_ok, wr_ok, drain_issue, out_accept;
    logic [SIZE-1:0] fill_addr;

    logic signed [bit_width-1:0] bk_re_a [2];
    logic signed [bit_width-1:0] bk_im_a [2];
    logic signed [bit_width-1:0] bk_re_b [2];
    logic signed [bit_width-1:0] bk_im_b [2];

    assign load_ready  = state_q[fill_sel_q] inside {BANK_FREE, BANK_FILL};
    assign fill_ok     = load_valid && load_ready;
    assign fill_addr   = (BITREV_LOAD != 0) ? SIZE'(bitrev(32'(load_cnt_q), SIZE)) : load_cnt_q;
    assign comp_active = (state_q[comp_sel_q] == BANK_COMPUTE);
    assign rd_ok       = rd_en && comp_active;
    assign wr_ok       = wr_en && comp_active;
    assign out_accept  = out_valid_q && out_ready;
    assign drain_issue = (state_q[drain_sel_q] == BANK_DRAIN) && (drain_cnt_q < DRAIN_END)
                         && (!out_valid_q || out_ready);

    // NOTE: every always_comb target takes its hold value first, so no latch is inferred.
    always_comb begin
        state_d         = state_q;
        fill_sel_d      = fill_sel_q;
        comp_sel_d      = comp_sel_q;
        drain_sel_d     = drain_sel_q;
        load_cnt_d      = load_cnt_q;
        drain_cnt_d     = drain_cnt_q;
        compute_start_d = 1'b0;
        compute_bank_d  = compute_bank_q;
        rd_valid_d      = rd_ok;
        out_valid_d     = out_valid_q;
        out_last_d      = out_last_q;
        out_bank_d      = out_bank_q;

        if (fill_ok) begin
            state_d[fill_sel_q] = BANK_FILL;
            load_cnt_d          = load_cnt_q + 1'b1;
            if (load_cnt_q == LOAD_LAST) begin
                state_d[fill_sel_q] = BANK_READY;
                load_cnt_d          = '0;
                fill_sel_d          = ~fill_sel_q;
            end
        end

        if (state_q[comp_sel_q] == BANK_READY) begin
            state_d[comp_sel_q] = BANK_COMPUTE;
            compute_start_d     = 1'b1;
            compute_bank_d      = comp_sel_q;
        end

        if (compute_done && comp_active) begin
            state_d[comp_sel_q] = BANK_DRAIN;
            comp_sel_d          = ~comp_sel_q;
        end

        if (drain_issue) begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            out_valid_d = 1'b1;
            out_last_d  = (drain_cnt_q == DRAIN_LAST);
            out_bank_d  = drain_sel_q;
        end else if (out_accept) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (out_accept && out_last_q) begin
            state_d[drain_sel_q] = BANK_FREE;
            drain_sel_d          = ~drain_sel_q;
            drain_cnt_d          = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q[0]      <= BANK_FREE;
            state_q[1]      <= BANK_FREE;
            fill_sel_q      <= 1'b0;
            comp_sel_q      <= 1'b0;
            drain_sel_q     <= 1'b0;
            load_cnt_q      <= '0;
            drain_cnt_q     <= '0;
            compute_start_q <= 1'b0;
            compute_bank_q  <= 1'b0;
            rd_valid_q      <= 1'b0;
            out_valid_q     <= 1'b0;
            out_last_q      <= 1'b0;
            out_bank_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            fill_sel_q      <= fill_sel_d;
            comp_sel_q      <= comp_sel_d;
            drain_sel_q     <= drain_sel_d;
            load_cnt_q      <= load_cnt_d;
            drain_cnt_q     <= drain_cnt_d;
            compute_start_q <= compute_start_d;
            compute_bank_q  <= compute_bank_d;
            rd_valid_q      <= rd_valid_d;
            out_valid_q     <= out_valid_d;
            out_last_q      <= out_last_d;
            out_bank_q      <= out_bank_d;
        end
    end

    // Fill owns port a of its bank; compute owns both write ports of the other.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic fill_here, comp_here, drain_here;
        assign fill_here  = fill_ok && (fill_sel_q == 1'(b));
        assign comp_here  = (comp_sel_q == 1'(b));
        assign drain_here = drain_issue && (drain_sel_q == 1'(b));

        fft_ram_bank #(.bit_width(bit_width), .SIZE(SIZE)) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .we_a    (fill_here || (wr_ok && comp_here)),
            .waddr_a (fill_here ? fill_addr : wr_ptr_a),
            .wre_a   (fill_here ? load_re : wr_re_a),
            .wim_a   (fill_here ? load_im : wr_im_a),
            .we_b    (wr_ok && comp_here),
            .waddr_b (wr_ptr_b),
            .wre_b   (wr_re_b),
            .wim_b   (wr_im_b),
            .re_a    (drain_here || (rd_ok && comp_here)),
            .raddr_a (drain_here ? drain_cnt_q[SIZE-1:0] : rd_ptr_a),
            .re_b    (rd_ok && comp_here),
            .raddr_b (rd_ptr_b),
            .rre_a   (bk_re_a[b]),
            .rim_a   (bk_im_a[b]),
            .rre_b   (bk_re_b[b]),
            .rim_b   (bk_im_b[b])
        );
    end

    assign compute_start = compute_start_q;
    assign compute_bank  = compute_bank_q;
    assign rd_valid      = rd_valid_q;
    assign rd_re_a       = bk_re_a[compute_bank_q];
    assign rd_im_a       = bk_im_a[compute_bank_q];
    assign rd_re_b       = bk_re_b[compute_bank_q];
    assign rd_im_b       = bk_im_b[compute_bank_q];
    assign out_valid     = out_valid_q;
    assign out_last      = out_last_q;
    assign out_re        = bk_re_a[out_bank_q];
    assign out_im        = bk_im_a[out_bank_q];

endmodule

// File: doc/fft_pingpong_ram.md
Name: fft_pingpong_ram

Overview:
Two-bank complex sample memory for the radix-2 FFT datapath. It replaces the single-bank load/compute/output RAM.
- One bank fills from the input stream while the other bank serves butterfly traffic or drains results.
- Input addresses are bit-reversed internally (optional).
- Compute side has dual read and dual write ports, so a full butterfly pair moves per cycle.
- Results drain in natural order over a valid/ready stream.

Parameters:
- bit_width, 29, width of each real/imag component (signed)
- N, 16, points per frame; power of two, minimum 4
- SIZE, 4, log2(N); address width
- BITREV_LOAD, 1, 1: load sample k goes to address rev(k); 0: it goes to address k

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_valid  in  1  input sample present
- load_ready  out  1  fill bank can accept a sample
- load_re / load_im  in  bit_width each  input sample, signed
- compute_start  out  1  one-cycle pulse: a bank is now owned by compute
- compute_bank  out  1  index of the bank owned by compute
- compute_done  in  1  pulse: butterflies finished on the compute bank
- rd_en  in  1  butterfly read request
- rd_ptr_a / rd_ptr_b  in  SIZE each  butterfly read addresses
- rd_re_a / rd_im_a / rd_re_b / rd_im_b  out  bit_width each  read data, signed
- rd_valid  out  1  read data valid
- wr_en  in  1  butterfly write-back
- wr_ptr_a / wr_ptr_b  in  SIZE each  write addresses
- wr_re_a / wr_im_a / wr_re_b / wr_im_b  in  bit_width each  write data, signed
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_re / out_im  out  bit_width each  output sample, signed
- out_last  out  1  marks sample N-1 of a frame

Behaviour:
- Clocking: single clock clk; reset rst_n is asynchronous, active-low.
- Per-bank state: FREE -> FILL -> READY -> COMPUTE -> DRAIN -> FREE.
- Three 1-bit role pointers, fill_sel, comp_sel and drain_sel. Each toggles when its phase completes, so frames are strictly FIFO.
- Reset:
  - both banks FREE; all selects 0; load counter 0; drain counter 0.
  - rd_valid, out_valid, out_last, compute_start = 0; rd_*/out_re/out_im = 0; compute_bank = 0.
  - Memory contents are not reset.
- Reset mid-operation aborts every frame immediately and returns to the reset state.
- load_ready:
  - combinational: high when state[fill_sel] is FREE or FILL.
  - therefore 1 immediately after reset.
- Load:
  - A sample is accepted on a clock edge with load_valid && load_ready.
  - It is written the same edge to address (BITREV_LOAD ? rev(cnt) : cnt) of the fill bank; bank goes FILL on the first accept.
  - On accept of sample N-1: bank goes READY, counter returns to 0, fill_sel toggles.
- Compute entry:
  - When state[comp_sel]==READY, at the next edge the bank goes COMPUTE.
  - compute_start pulses 1 cycle and compute_bank = comp_sel (held until the next compute_start).
  - Earliest compute_start is the 2nd edge after the last load accept.
- Reads:
  - rd_en in COMPUTE: rd_* is registered from the compute bank 1 cycle later, with rd_valid=1.
  - rd_en with no COMPUTE bank: ignored, rd_valid=0.
- Writes:
  - wr_en in COMPUTE writes both ports at the edge.
  - wr_ptr_a==wr_ptr_b: port b wins.
  - Same-cycle read and write of one address: the read returns the old data.
  - wr_en outside COMPUTE: ignored.
- compute_done:
  - In COMPUTE: bank goes DRAIN and comp_sel toggles.
  - Otherwise: ignored.
  - Simultaneous with rd_en/wr_en: that cycle's access still completes.
- Drain:
  - While state[drain_sel]==DRAIN, a read of address d is issued when (d<N) && (!out_valid || out_ready); d increments on each issue.
  - Data lands in the out_* registers 1 cycle later.
  - Throughput is 1 sample per cycle when out_ready is held high.
  - While stalled, out_* are held stable.
  - out_last = 1 on sample N-1.
  - On acceptance of the last sample: bank goes FREE, drain_sel toggles, d returns to 0.
- Concurrency:
  - fill, compute and drain never target the same bank; the pointer ordering guarantees this.
  - a fill write and a compute write in the same cycle go to different banks.

Decomposition:
- Shared package fft_ram_pkg:
  - bank-state enum (FREE, FILL, READY, COMPUTE, DRAIN)
  - bitrev function parametrised by SIZE
  - role-select typedef
- Sub-module fft_ram_bank, instantiated twice:
  - N-deep complex storage
  - two write ports, with port b priority
  - two registered read ports, used for compute reads and drain reads
- Top-level holds the role pointers, counters and stream logic.

Test Plan:
- Reset; load 16 samples re=k, im=-k (BITREV_LOAD=1) -> compute_start 2 cycles after 16th accept, compute_bank=0; rd_en with rd_ptr_a=1, rd_ptr_b=2 -> next cycle rd_re_a=8, rd_im_a=-8, rd_re_b=4, rd_valid=1.
- wr_en with wr_ptr_a=3 (100,7), wr_ptr_b=11 (-5,0), plus same-cycle rd_ptr_a=3 -> read returns old value 12; next read of 3 gives (100,7) and of 11 gives (-5,0).
- wr_ptr_a=wr_ptr_b=5, data a=(1,1), data b=(2,2) -> address 5 reads (2,2).
- Ping-pong: frame 2 loads while bank 0 is in COMPUTE -> load_ready=1 throughout; after frame 2 is READY, load_ready=0 until bank 0 drains; frame 2 compute_start follows frame 1 compute_done; compute_bank=1.
- compute_done, then out_ready pattern 1,0,0,1 repeating -> 16 samples in address order 0..15; data stable during stalls; out_last only on the 16th; load_ready rises the cycle after the last accept.
- Assert rst_n=0 mid-drain (sample 7) -> asynchronously out_valid=0, compute_start=0; after release load_ready=1; a new frame loads into bank 0.
